// File: rtl/unsigned_mul_8x8_ha_seq_ctrl.sv
// Sequenced approximate 8x8 unsigned multiplier.
// The operands are registered and drive a four-row half-adder array. The rows
// are then folded into a shared 16-bit accumulator, ROWS_PER_CYCLE rows per
// cycle. The result is held under a valid/ready handshake until the consumer
// takes it.
module unsigned_mul_8x8_ha_seq_ctrl #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  // Only 1, 2 or 4 rows per cycle divide the four rows evenly.
  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : gBadRowsPerCycle
    $error("ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The row counter steps by ROWS_PER_CYCLE. A step of 4 truncates to 0,
  // which is fine because a single accumulate cycle covers every row.
  localparam logic [1:0] CNT_STEP = 2'(ROWS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - ROWS_PER_CYCLE);

  // These are the row-0 columns where the front end ORs the two partial-product
  // bits instead of half-adding them. The error is intentional.
  localparam logic [7:0] OR_COLS = 8'b0010_1110;

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  rowCnt_q, rowCnt_d;
  logic [7:0]  xOp_q, xOp_d;
  logic [7:0]  yOp_q, yOp_d;

  logic [8:0]  haT [4];
  logic [6:0]  haB [4];
  logic [15:0] wRow [4];
  logic [15:0] stepSum;
  logic        lastStep;

  // Half-adder array front end, driven only from the captured operands.
  // Row k pairs partial products x[2k]&y and x[2k+1]&y.
  always_comb begin
    logic [7:0] ppLo;
    logic [7:0] ppHi;
    for (int k = 0; k < 4; k++) begin
      ppLo = {8{xOp_q[2*k]}} & yOp_q;
      ppHi = {8{xOp_q[2*k+1]}} & yOp_q;
      haT[k] = '0;
      haB[k] = '0;
      haT[k][0] = ppLo[0];
      haT[k][8] = ppHi[7];
      for (int j = 1; j < 8; j++) begin
        if (k == 0 && OR_COLS[j]) begin
          haT[k][j]   = ppLo[j] | ppHi[j-1];
          haB[k][j-1] = 1'b0;
        end else begin
          haT[k][j]   = ppLo[j] ^ ppHi[j-1];
          haB[k][j-1] = ppLo[j] & ppHi[j-1];
        end
      end
    end
  end

  // Collapse each row's sum and carry vectors, then weight the row by 4^k.
  always_comb begin
    logic [9:0] rowVal;
    for (int k = 0; k < 4; k++) begin
      rowVal  = {1'b0, haT[k]} + {1'b0, haB[k], 2'b00};
      wRow[k] = {6'd0, rowVal} << (2 * k);
    end
  end

  // Add the rows scheduled for this accumulate cycle.
  always_comb begin
    stepSum = '0;
    for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
      stepSum = stepSum + wRow[rowCnt_q + 2'(i)];
    end
  end

  assign lastStep = (rowCnt_q == LAST_CNT);

  // Sequencer: accept an operand pair, accumulate the rows, then present the result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rowCnt_d = rowCnt_q;
    xOp_d    = xOp_q;
    yOp_d    = yOp_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          xOp_d    = x;
          yOp_d    = y;
          acc_d    = '0;
          rowCnt_d = '0;
          state_d  = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d    = acc_q + stepSum;
        rowCnt_d = rowCnt_q + CNT_STEP;
        if (lastStep) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. A reset in mid-operation discards the pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rowCnt_q <= '0;
      xOp_q    <= '0;
      yOp_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rowCnt_q <= rowCnt_d;
      xOp_q    <= xOp_d;
      yOp_q    <= yOp_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ACC) || (state_q == ST_DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_seq_ctrl.sv
// Directed bench for the sequenced approximate multiplier. Instance 0 uses one
// row per cycle. Instances 1 and 2 use two and four rows per cycle and are
// exercised by the streaming scenario.
module tb_unsigned_mul_8x8_ha_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inValid  [3];
  logic        inReady  [3];
  logic [7:0]  xIn      [3];
  logic [7:0]  yIn      [3];
  logic        outValid [3];
  logic        outReady [3];
  logic [15:0] product  [3];
  logic        busy     [3];

  int checks;
  int passed;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int RPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    unsigned_mul_8x8_ha_seq_ctrl #(.ROWS_PER_CYCLE(RPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .x         (xIn[g]),
      .y         (yIn[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .product   (product[g]),
      .busy      (busy[g])
    );
  end

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the exact product minus the carries that the row-0 OR
  // columns drop. Those carries matter only when x[0] and x[1] are both set.
  function automatic logic [15:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] loss;
    loss = 16'd0;
    if (a[0] && a[1]) begin
      if (b[1] && b[0]) loss = loss + 16'd2;
      if (b[2] && b[1]) loss = loss + 16'd4;
      if (b[3] && b[2]) loss = loss + 16'd8;
      if (b[5] && b[4]) loss = loss + 16'd32;
    end
    return ({8'd0, a} * {8'd0, b}) - loss;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation. Returns the product and the number of edges from accept to out_valid.
  task automatic doOp(input int g, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output int lat);
    int guard;
    guard = 0;
    while (!inReady[g] && guard < 20) begin
      tick();
      guard++;
    end
    xIn[g] = a;
    yIn[g] = b;
    inValid[g] = 1'b1;
    tick();
    inValid[g] = 1'b0;
    lat = 0;
    while (!outValid[g] && lat < 20) begin
      tick();
      lat++;
    end
    res = product[g];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (inReady[0] !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", inReady[0]); else passed++;
    checks++; if (outValid[0] !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", outValid[0]); else passed++;
    checks++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy[0]); else passed++;
    checks++; if (product[0] !== 16'd0) $display("FAIL reset_product: got %0d expected 0", product[0]); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_corner();
    logic [15:0] res;
    int lat;
    doOp(0, 8'd255, 8'd255, res, lat);
    checks++; if (res !== 16'd64979) $display("FAIL corner_product: got %0d expected 64979", res); else passed++;
    checks++; if (lat !== 4) $display("FAIL corner_latency: got %0d expected 4", lat); else passed++;
    tick();
    checks++; if (outValid[0] !== 1'b0) $display("FAIL corner_valid_drop: got %0b expected 0", outValid[0]); else passed++;
    checks++; if (inReady[0] !== 1'b1) $display("FAIL corner_ready_back: got %0b expected 1", inReady[0]); else passed++;
  endtask

  task automatic test_row0();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] ve [4];
    logic [15:0] res;
    int lat;
    va = '{8'd3, 8'd3, 8'd4, 8'd0};
    vb = '{8'd3, 8'd1, 8'd5, 8'd200};
    ve = '{16'd7, 16'd3, 16'd20, 16'd0};
    for (int i = 0; i < 4; i++) begin
      doOp(0, va[i], vb[i], res, lat);
      checks++;
      if (res !== ve[i]) $display("FAIL row0_%0dx%0d: got %0d expected %0d", va[i], vb[i], res, ve[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res;
    int lat;
    outReady[0] = 1'b0;
    doOp(0, 8'd200, 8'd100, res, lat);
    checks++; if (res !== 16'd20000) $display("FAIL bp_product: got %0d expected 20000", res); else passed++;
    for (int i = 0; i < 5; i++) begin
      inValid[0] = ~inValid[0];
      xIn[0] = 8'(i * 37);
      tick();
      checks++; if (outValid[0] !== 1'b1) $display("FAIL bp_hold_valid_%0d: got %0b expected 1", i, outValid[0]); else passed++;
      checks++; if (product[0] !== 16'd20000) $display("FAIL bp_hold_product_%0d: got %0d expected 20000", i, product[0]); else passed++;
      checks++; if (inReady[0] !== 1'b0) $display("FAIL bp_hold_ready_%0d: got %0b expected 0", i, inReady[0]); else passed++;
    end
    inValid[0] = 1'b0;
    outReady[0] = 1'b1;
    tick();
    checks++; if (outValid[0] !== 1'b0) $display("FAIL bp_release_valid: got %0b expected 0", outValid[0]); else passed++;
    checks++; if (inReady[0] !== 1'b1) $display("FAIL bp_release_ready: got %0b expected 1", inReady[0]); else passed++;
  endtask

  task automatic test_reset_mid_acc();
    logic [15:0] res;
    int lat;
    bit leaked;
    xIn[0] = 8'd123;
    yIn[0] = 8'd45;
    inValid[0] = 1'b1;
    tick();
    inValid[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (outValid[0] !== 1'b0) $display("FAIL midrst_out_valid: got %0b expected 0", outValid[0]); else passed++;
    checks++; if (busy[0] !== 1'b0) $display("FAIL midrst_busy: got %0b expected 0", busy[0]); else passed++;
    checks++; if (inReady[0] !== 1'b1) $display("FAIL midrst_in_ready: got %0b expected 1", inReady[0]); else passed++;
    checks++; if (product[0] !== 16'd0) $display("FAIL midrst_product: got %0d expected 0", product[0]); else passed++;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (outValid[0]) leaked = 1'b1;
    end
    checks++; if (leaked !== 1'b0) $display("FAIL midrst_no_result: got %0b expected 0", leaked); else passed++;
    doOp(0, 8'd2, 8'd7, res, lat);
    checks++; if (res !== 16'd14) $display("FAIL midrst_next_op: got %0d expected 14", res); else passed++;
    tick();
  endtask

  task automatic test_isolation();
    int lat;
    xIn[0] = 8'd13;
    yIn[0] = 8'd11;
    inValid[0] = 1'b1;
    tick();
    inValid[0] = 1'b0;
    lat = 0;
    while (!outValid[0] && lat < 20) begin
      xIn[0] = 8'($urandom);
      yIn[0] = 8'($urandom);
      tick();
      lat++;
    end
    checks++; if (product[0] !== 16'd143) $display("FAIL isolation_product: got %0d expected 143", product[0]); else passed++;
    tick();
  endtask

  task automatic test_streaming();
    int expGap [3];
    int nOps;
    expGap = '{6, 4, 3};
    nOps = 1000;
    for (int g = 0; g < 3; g++) begin
      logic [15:0] expQ [$];
      int cyc;
      int lastAcc;
      int accepted;
      int results;
      bit willAccept;
      logic [15:0] expVal;
      cyc = 0;
      lastAcc = -1;
      accepted = 0;
      results = 0;
      outReady[g] = 1'b1;
      xIn[g] = 8'd255;
      yIn[g] = 8'd255;
      while (results < nOps && cyc < nOps * 8 + 50) begin
        inValid[g] = (accepted < nOps);
        willAccept = inReady[g] && inValid[g];
        tick();
        cyc++;
        if (willAccept) begin
          expQ.push_back(refMul(xIn[g], yIn[g]));
          if (lastAcc >= 0) begin
            checks++;
            if (cyc - lastAcc !== expGap[g]) $display("FAIL stream%0d_gap_op%0d: got %0d expected %0d", g, accepted, cyc - lastAcc, expGap[g]);
            else passed++;
          end
          lastAcc = cyc;
          accepted++;
          if (accepted == 1) begin
            xIn[g] = 8'd0;
            yIn[g] = 8'd0;
          end else begin
            xIn[g] = 8'($urandom);
            yIn[g] = 8'($urandom);
          end
        end
        if (outValid[g]) begin
          expVal = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
          checks++;
          if (product[g] !== expVal) $display("FAIL stream%0d_result%0d: got %0d expected %0d", g, results, product[g], expVal);
          else passed++;
          results++;
        end
      end
      inValid[g] = 1'b0;
      checks++;
      if (results !== nOps) $display("FAIL stream%0d_completion: got %0d results expected %0d", g, results, nOps);
      else passed++;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      inValid[g]  = 1'b0;
      outReady[g] = 1'b1;
      xIn[g]      = 8'd0;
      yIn[g]      = 8'd0;
    end
    test_reset();
    test_corner();
    test_row0();
    test_backpressure();
    test_reset_mid_acc();
    test_isolation();
    test_streaming();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
